// File: rtl/debug_bus_bridge.sv
// Byte-serial debug command bridge: opcode, address and data bytes in,
// one 32-bit bus access out, response bytes back.
module debug_bus_bridge #(
  parameter int unsigned RX_TIMEOUT  = 100000,
  parameter int unsigned BUS_TIMEOUT = 1024
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ready
);

  localparam int unsigned RXW = $clog2(RX_TIMEOUT + 1);
  localparam int unsigned BSW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [RXW-1:0] RX_LAST  = RXW'(RX_TIMEOUT - 1);
  localparam logic [BSW-1:0] BUS_LAST = BSW'(BUS_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

  state_t          state_q;
  logic            rw_q;
  logic [1:0]      cnt_q;
  logic [RXW-1:0]  gap_q;
  logic [BSW-1:0]  bus_cnt_q;
  logic            req_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic            txv_q;
  logic [7:0]      txd_q;
  logic [23:0]     shift_q;
  logic [1:0]      left_q;

  assign o_bus_request = req_q;
  assign o_bus_rw      = rw_q;
  assign o_bus_address = addr_q;
  assign o_bus_wdata   = wdata_q;
  assign o_tx_valid    = txv_q;
  assign o_tx_data     = txd_q;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      rw_q      <= 1'b0;
      cnt_q     <= '0;
      gap_q     <= '0;
      bus_cnt_q <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      txv_q     <= 1'b0;
      txd_q     <= '0;
      shift_q   <= '0;
      left_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          txv_q <= 1'b0;
          if (i_rx_valid) begin
            if (i_rx_data == 8'h01 || i_rx_data == 8'h02) begin
              rw_q    <= (i_rx_data == 8'h01);
              cnt_q   <= '0;
              gap_q   <= '0;
              state_q <= S_ADDR;
            end else begin
              txv_q   <= 1'b1;
              txd_q   <= 8'hEE;
              left_q  <= '0;
              state_q <= S_RESP;
            end
          end
        end
        S_ADDR, S_DATA: begin
          if (i_rx_valid) begin
            gap_q <= '0;
            cnt_q <= cnt_q + 2'd1;
            // Little-endian: shifting in from the top lands byte 0 in [7:0]
            if (state_q == S_ADDR)
              addr_q <= {i_rx_data, addr_q[31:8]};
            else
              wdata_q <= {i_rx_data, wdata_q[31:8]};
            if (cnt_q == 2'd3) begin
              if (state_q == S_ADDR && rw_q) begin
                state_q <= S_DATA;
              end else begin
                state_q   <= S_BUS;
                req_q     <= 1'b1;
                bus_cnt_q <= '0;
              end
            end
          end else if (gap_q >= RX_LAST) begin
            gap_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q + RXW'(1);
          end
        end
        S_BUS: begin
          if (i_bus_ready) begin
            req_q     <= 1'b0;
            bus_cnt_q <= '0;
            txv_q     <= 1'b1;
            state_q   <= S_RESP;
            if (rw_q) begin
              txd_q  <= 8'hA5;
              left_q <= 2'd0;
            end else begin
              txd_q   <= i_bus_rdata[7:0];
              shift_q <= i_bus_rdata[31:8];
              left_q  <= 2'd3;
            end
          end else if (bus_cnt_q >= BUS_LAST) begin
            req_q     <= 1'b0;
            bus_cnt_q <= '0;
            txv_q     <= 1'b1;
            txd_q     <= 8'hEF;
            left_q    <= 2'd0;
            state_q   <= S_RESP;
          end else begin
            bus_cnt_q <= bus_cnt_q + BSW'(1);
          end
        end
        S_RESP: begin
          if (i_tx_ready) begin
            if (left_q == 2'd0) begin
              txv_q   <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              txd_q   <= shift_q[7:0];
              shift_q <= {8'h00, shift_q[23:8]};
              left_q  <= left_q - 2'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
